// File: rtl/rgb_stream_tx.sv
// rtl/rgb_stream_tx.sv - frame-bounded RGB pixel streamer with a small elastic FIFO
module rgb_stream_tx #(
  parameter int WIDTH  = 256,
  parameter int HEIGHT = 256,
  parameter int DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_pix_vld,
  input  logic [23:0] i_pix_data,
  output logic        i_pix_busy,
  output logic        o_rgb_vld,
  output logic [23:0] o_rgb_data,
  input  logic        o_rgb_busy,
  output logic        o_active,
  output logic        o_done,
  output logic [31:0] o_tx_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0]   TOTAL   = 32'(longint'(WIDTH) * longint'(HEIGHT));
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t        state, state_nxt;
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   acc_count, tx_count;
  logic          push, pop;

  // Handshakes derive only from registered state, so a pop at full cannot open a push slot.
  assign push       = i_pix_vld && !i_pix_busy;
  assign pop        = o_rgb_vld && !o_rgb_busy;
  assign o_rgb_data = mem[rd_ptr];
  assign o_tx_count = tx_count;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and state-decoded outputs; the frame ends on the final downstream transfer.
  always_comb begin
    state_nxt  = state;
    i_pix_busy = 1'b1;
    o_rgb_vld  = 1'b0;
    o_active   = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = STREAM;
      end
      STREAM: begin
        o_active   = 1'b1;
        i_pix_busy = !((count < DEPTH_C) && (acc_count < TOTAL));
        o_rgb_vld  = (count != '0);
        if ((count != '0) && !o_rgb_busy && (tx_count == TOTAL - 32'd1))
          state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_pix_data;
  end

  // Pointers, occupancy and frame counters; cleared on reset and on frame start.
  always_ff @(posedge i_clk) begin
    if (i_rst || (state == IDLE && i_start)) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      acc_count <= '0;
      tx_count  <= '0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        acc_count <= acc_count + 32'd1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        tx_count <= tx_count + 32'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_stream_tx.sv
// tb/tb_rgb_stream_tx.sv - randomized and directed bench for rgb_stream_tx against a queue model
module tb_rgb_stream_tx;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int D     = 4;
  localparam int TOTAL = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pix_vld = 1'b0;
  logic [23:0] pix_data = '0;
  logic        i_pix_busy;
  logic        o_rgb_vld;
  logic [23:0] o_rgb_data;
  logic        rgb_busy = 1'b0;
  logic        o_active;
  logic        o_done;
  logic [31:0] o_tx_count;

  int checks = 0;
  int errors = 0;

  rgb_stream_tx #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_pix_vld(pix_vld), .i_pix_data(pix_data), .i_pix_busy(i_pix_busy),
    .o_rgb_vld(o_rgb_vld), .o_rgb_data(o_rgb_data), .o_rgb_busy(rgb_busy),
    .o_active(o_active), .o_done(o_done), .o_tx_count(o_tx_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a frame is active or just done; the FIFO is a plain queue.
  bit m_act = 0, m_done = 0, chk_en = 0, m_pu, m_po;
  int m_acc = 0, m_tx = 0;
  int q[$];

  always @(posedge clk) begin
    m_pu = pix_vld && m_act && (q.size() < D) && (m_acc < TOTAL);
    m_po = m_act && (q.size() > 0) && !rgb_busy;
    if (rst) begin
      m_act = 0; m_done = 0; q.delete(); m_acc = 0; m_tx = 0; chk_en = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1; q.delete(); m_acc = 0; m_tx = 0;
      end
    end else begin
      if (m_po) begin void'(q.pop_front()); m_tx++; end
      if (m_pu) begin q.push_back(int'(pix_data)); m_acc++; end
      if (m_po && m_tx == TOTAL) begin m_act = 0; m_done = 1; end
    end
  end

  // Compare every cycle, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pix_busy", 32'(i_pix_busy), 32'(!(m_act && q.size() < D && m_acc < TOTAL)));
      check("rgb_vld",  32'(o_rgb_vld),  32'(m_act && q.size() > 0));
      check("active",   32'(o_active),   32'(m_act));
      check("done",     32'(o_done),     32'(m_done));
      check("tx_count", o_tx_count,      32'(m_tx));
      if (m_act && q.size() > 0) check("rgb_data", 32'(o_rgb_data), 32'(q[0]));
    end
  end

  // Log what the DUT actually emits and count done pulses.
  logic [23:0] emitted[$];
  int done_cnt = 0;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (o_rgb_vld && !rgb_busy) emitted.push_back(o_rgb_data);
      if (o_done) done_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] d);
    int n = 0;
    pix_vld = 1'b1;
    pix_data = d;
    while (i_pix_busy && n < 50) begin cyc(); n++; end
    check("send_timeout", 32'(n < 50), 32'd1);
    cyc();
    pix_vld = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!o_done && n < 200) begin cyc(); n++; end
    check("done_timeout", 32'(n < 200), 32'd1);
    cyc();
  endtask

  task automatic check_frame(input string name, input int base);
    check({name, "_len"}, 32'(emitted.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < emitted.size()) check(name, 32'(emitted[i]), 32'(base + i + 1));
  endtask

  initial begin
    int d0, n;

    // Reset for two cycles.
    cyc(); cyc();
    rst = 1'b0;
    check("rst_busy", 32'(i_pix_busy), 32'd1);
    check("rst_vld", 32'(o_rgb_vld), 32'd0);
    check("rst_active", 32'(o_active), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_tx", o_tx_count, 32'd0);
    cyc();

    // Free-running frame.
    emitted.delete();
    d0 = done_cnt;
    pulse_start();
    for (int i = 1; i <= 8; i++) send(24'(i));
    wait_done();
    cyc();
    check_frame("free_order", 0);
    check("free_done_once", 32'(done_cnt - d0), 32'd1);
    check("free_tx", o_tx_count, 32'd8);

    // Backpressure, then simultaneous pop at full with a pending push.
    emitted.delete();
    rgb_busy = 1'b1;
    pulse_start();
    for (int i = 1; i <= 4; i++) send(24'(i));
    pix_vld = 1'b1;
    pix_data = 24'd5;
    cyc(); cyc(); cyc();
    check("bp_full_busy", 32'(i_pix_busy), 32'd1);
    check("bp_head", 32'(o_rgb_data), 32'h1);
    check("bp_tx", o_tx_count, 32'd0);
    rgb_busy = 1'b0;
    cyc();
    check("full_pop_tx", o_tx_count, 32'd1);
    check("full_pop_busy", 32'(i_pix_busy), 32'd0);
    check("full_pop_head", 32'(o_rgb_data), 32'h2);
    cyc();
    pix_vld = 1'b0;
    for (int i = 6; i <= 8; i++) send(24'(i));
    wait_done();
    check_frame("bp_order", 0);
    check("bp_final_tx", o_tx_count, 32'd8);

    // Overflow offer and ignored second start.
    emitted.delete();
    rgb_busy = 1'b1;
    pulse_start();
    for (int i = 1; i <= 8; i++) begin
      if (i > 4) begin rgb_busy = 1'b0; cyc(); rgb_busy = 1'b1; end
      send(24'(i));
    end
    pix_vld = 1'b1;
    pix_data = 24'd9;
    pulse_start();
    cyc(); cyc();
    check("ovf_busy", 32'(i_pix_busy), 32'd1);
    check("ovf_active", 32'(o_active), 32'd1);
    check("ovf_tx", o_tx_count, 32'd4);
    rgb_busy = 1'b0;
    wait_done();
    pix_vld = 1'b0;
    cyc();
    check_frame("ovf_order", 0);

    // Reset mid-frame, then a clean frame.
    d0 = done_cnt;
    pulse_start();
    for (int i = 1; i <= 3; i++) send(24'(i));
    n = 0;
    while (o_tx_count != 32'd3 && n < 50) begin cyc(); n++; end
    check("mid_wait", 32'(n < 50), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_vld", 32'(o_rgb_vld), 32'd0);
    check("mid_tx", o_tx_count, 32'd0);
    check("mid_active", 32'(o_active), 32'd0);
    cyc(); cyc();
    check("mid_no_done", 32'(done_cnt - d0), 32'd0);
    emitted.delete();
    pulse_start();
    for (int i = 1; i <= 8; i++) send(24'(32'h100 + i));
    wait_done();
    check_frame("clean_order", 32'h100);

    // Randomized traffic against the model.
    d0 = done_cnt;
    repeat (4000) begin
      rst      = ($urandom_range(0, 599) == 0);
      start    = ($urandom_range(0, 15) == 0);
      pix_vld  = 1'($urandom_range(0, 1));
      pix_data = 24'($urandom);
      rgb_busy = ($urandom_range(0, 3) == 0);
      cyc();
    end
    rst = 1'b0; start = 1'b0; pix_vld = 1'b0; rgb_busy = 1'b0;
    cyc(); cyc();
    check("rand_frames_done", 32'(done_cnt > d0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_stream_tx.md
RGB_STREAM_TX -- requirements
Module: rgb_stream_tx

Interface
REQ-001 Parameter WIDTH, default 256: pixels per row, range 1..65535.
REQ-002 Parameter HEIGHT, default 256: rows per frame, range 1..65535.
REQ-003 Parameter DEPTH, default 4: FIFO entries, power of two, range 2..16.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 i_clk  in  1  clock; all state updates on rising edge.
REQ-006 i_rst  in  1  synchronous active-high reset.
REQ-007 i_start  in  1  one-cycle request to begin a frame.
REQ-008 i_pix_vld  in  1  upstream pixel valid.
REQ-009 i_pix_data  in  24  upstream pixel {R[23:16],G[15:8],B[7:0]}.
REQ-010 i_pix_busy  out  1  upstream stall; pixel accepted when i_pix_vld=1 and i_pix_busy=0.
REQ-011 o_rgb_vld  out  1  downstream pixel valid.
REQ-012 o_rgb_data  out  24  downstream pixel, same packing.
REQ-013 o_rgb_busy  in  1  downstream stall; transfer when o_rgb_vld=1 and o_rgb_busy=0.
REQ-014 o_active  out  1  high while a frame is in progress.
REQ-015 o_done  out  1  one-cycle pulse at frame end.
REQ-016 o_tx_count  out  32  pixels transferred downstream in the current or last frame.

Function
REQ-017 The FSM SHALL have states IDLE, STREAM and DONE.
REQ-018 IDLE -> STREAM on i_start=1; in the same edge, clear the accept count, o_tx_count and the FIFO.
REQ-019 i_start SHALL be ignored in STREAM and DONE.
REQ-020 STREAM -> DONE on the edge of the downstream transfer numbered WIDTH*HEIGHT.
REQ-021 DONE -> IDLE unconditionally after one cycle.
REQ-022 o_done=1 exactly while in DONE.
REQ-023 o_active=1 exactly while in STREAM.
REQ-024 i_pix_busy=0 only when state=STREAM, FIFO occupancy<DEPTH and accept count<WIDTH*HEIGHT; otherwise it SHALL be 1.
REQ-025 i_pix_busy SHALL be a function of registered state only; a simultaneous pop at full SHALL NOT permit a push in that cycle.
REQ-026 Each upstream accept SHALL write i_pix_data to the FIFO tail and increment the 32-bit accept count.
REQ-027 o_rgb_vld SHALL equal (state=STREAM and FIFO non-empty).
REQ-028 o_rgb_data SHALL equal the FIFO head.
REQ-029 A pixel accepted on edge N SHALL appear on o_rgb_vld/o_rgb_data after edge N when the FIFO was empty, giving 1-cycle latency.
REQ-030 While o_rgb_vld=1 and o_rgb_busy=1, o_rgb_vld and o_rgb_data SHALL hold stable.
REQ-031 Each downstream transfer SHALL pop the head and increment o_tx_count.
REQ-032 A simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-033 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-034 o_tx_count SHALL hold its final value through DONE and IDLE until the next i_start.
REQ-035 Pixels SHALL be emitted in exactly the order accepted; none dropped, none duplicated.

Reset
REQ-036 While i_rst=1 at a rising edge: state=IDLE, FIFO empty, pointers=0, accept count=0, o_tx_count=0.
REQ-037 During reset, o_rgb_vld=0, o_active=0, o_done=0 and i_pix_busy=1, taking effect at the next edge.
REQ-038 o_rgb_data after reset SHALL be don't-care while o_rgb_vld=0.
REQ-039 Reset mid-frame SHALL discard FIFO contents and abort the frame without an o_done pulse.
REQ-040 i_rst SHALL take priority over i_start and all handshakes in the same cycle.

Verification (WIDTH=4, HEIGHT=2, DEPTH=4)
REQ-041 Reset check: assert i_rst 2 cycles -> i_pix_busy=1, o_rgb_vld=0, o_active=0, o_done=0, o_tx_count=0.
REQ-042 Free-running frame: i_start, then 8 pixels 0x000001..0x000008 back-to-back, o_rgb_busy=0 -> outputs 0x000001..0x000008 in order, each 1 cycle after its accept; o_done pulses once; o_tx_count=8.
REQ-043 Backpressure: hold o_rgb_busy=1 from frame start while 5 pixels are offered -> 4 accepted, then i_pix_busy=1; o_rgb_data=0x000001 stable; release busy -> all 8 pixels delivered in order.
REQ-044 Simultaneous push and pop at full: with FIFO full, drop o_rgb_busy while i_pix_vld=1 -> pop occurs, no push that cycle, push on the next cycle; no loss.
REQ-045 Overflow: offer a 9th pixel after 8 are accepted -> i_pix_busy=1 and it is never emitted; a second i_start during STREAM -> no effect.
REQ-046 Reset mid-frame: assert i_rst after 3 transfers -> o_rgb_vld=0 and o_tx_count=0 next cycle, no o_done; a new i_start streams a clean 8-pixel frame.
